nibble_serial_add_ctrl: RTL and testbench

Sequencer that adds two WIDTH-bit operands over several cycles by reusing one 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
Carry is registered between nibbles.
Operands are accepted through a valid/ready handshake, and the result is presented through a second valid/ready handshake.
Used where wide adds are infrequent and area matters more than latency.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 10 +
 rtl/nibble_serial_add_ctrl_if.sv | 26 ++
 rtl/nibble_serial_add_ctrl_slice.sv | 21 ++
 rtl/nibble_serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_add_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the adder.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl_slice.sv
// 4-bit combinational ripple-carry adder built from per-bit full-adder cells.
module nibble_adder_slice
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder that walks one shared 4-bit slice across the operands, LSB nibble
// first, with the inter-nibble carry held in a register.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] sl_sum;
  logic                sl_cout;

  nibble_adder_slice u_slice (
    .a    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = sl_sum;
        carry_d = sl_cout;
        if (idx_q == IDX_LAST) begin
          // Park idx at 0 so it never leaves [0, NIBBLES-1] for non-power-of-2 counts.
          idx_d   = '0;
          cout_d  = sl_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for the nibble-serial adder at WIDTH=16.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: sum=%h cout=%b ovf=%b, want 0000 0 0", bus.sum, bus.cout, bus.ovf);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  // Single transaction with out_ready high; checks latency, result and pulse width.
  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eo, input string nm);
    int cyc;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    bus.a = ta;
    bus.b = tb_v;
    bus.cin = tc;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    bus.cin = 1'b1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b in_ready=%b, want 1 0", nm, bus.busy, bus.in_ready);
    end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles want 4", nm, cyc);
    end
    n_checks++;
    if (bus.sum !== es || bus.cout !== ec || bus.ovf !== eo) begin
      n_fail++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b, want %h %b %b",
               nm, bus.sum, bus.cout, bus.ovf, es, ec, eo);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_pulse: out_valid=%b in_ready=%b, want 0 1", nm, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_carry();
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_wrap");
    do_add(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, "carry_cin");
  endtask

  task automatic test_overflow();
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    bus.out_ready = 1'b0;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bad = 0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      if (bus.in_ready !== 1'b0) bad++;
      step();
      cyc++;
    end
    n_checks++;
    if (bad != 0 || cyc != 4) begin
      n_fail++;
      $display("FAIL bp_run: in_ready high %0d times, latency %0d, want 0 and 4", bad, cyc);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid !== 1'b1 || bus.sum !== 16'h3333 || bus.cout !== 1'b0 || bus.in_ready !== 1'b0)
        bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, sum=%h want 3333 held", bad, bus.sum);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 16'h3333) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b sum=%h, want 0 1 3333",
               bus.out_valid, bus.in_ready, bus.sum);
    end
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != 4 || bus.sum !== 16'hFFFF || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: latency %0d sum=%h cout=%b ovf=%b, want 4 ffff 0 0",
               cyc, bus.sum, bus.cout, bus.ovf);
    end
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_run();
    bus.out_ready = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h1111;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.sum !== 16'h0000 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_run: sum=%h busy=%b out_valid=%b in_ready=%b, want 0000 0 0 0",
               bus.sum, bus.busy, bus.out_valid, bus.in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    do_add(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [15:0] opa [3] = '{16'h0001, 16'h1000, 16'hF0F0};
    logic [15:0] opb [3] = '{16'h0002, 16'h2000, 16'h0F0F};
    logic [15:0] exp_s [3] = '{16'h0003, 16'h3000, 16'hFFFF};
    int acc_cyc [3];
    int na, nr, bad;
    logic rdy_prev;
    na = 0;
    nr = 0;
    bad = 0;
    bus.out_ready = 1'b1;
    bus.cin = 1'b0;
    bus.a = opa[0];
    bus.b = opb[0];
    bus.in_valid = 1'b1;
    rdy_prev = bus.in_ready;
    for (int c = 0; c < 60 && nr < 3; c++) begin
      step();
      if (rdy_prev && bus.in_valid) begin
        if (na < 3) acc_cyc[na] = c;
        na++;
        if (na < 3) begin
          bus.a = opa[na];
          bus.b = opb[na];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        if (nr < 3 && bus.sum !== exp_s[nr]) begin
          bad++;
          $display("FAIL b2b_result%0d: sum=%h want %h", nr, bus.sum, exp_s[nr]);
        end
        nr++;
      end
      rdy_prev = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (nr != 3 || na != 3 || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_count: accepts=%0d results=%0d bad=%0d, want 3 3 0", na, nr, bad);
    end
    n_checks++;
    if (na == 3 && (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6)) begin
      n_fail++;
      $display("FAIL b2b_spacing: gaps %0d %0d want 6 6",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
